comparator_word_sequencer: RTL and testbench

Word-level front/back end for the registered 1-bit comparator. Accepts two WIDTH-bit operands over a valid/ready handshake and feeds them MSB-first, one bit pair per cycle, into the comparator's `in1`/`in2`. It consumes the comparator's `eq`/`gt`/`lt` results and resolves the word relation from the first unequal bit, terminating early once that bit is seen. The resolved relation is presented on a held valid/ready output.

---
 rtl/comparator_word_sequencer.sv | 160 ++++++++++++++++
 tb/tb_comparator_word_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/comparator_word_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | comparator_word_sequencer                                              |
// | Serialises two operands MSB-first into a 1-bit comparator and resolves |
// | the word relation from the first unequal bit, with early termination.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module comparator_word_sequencer #(
  parameter int WIDTH   = 8,
  parameter int CMP_LAT = 1,
  localparam int CW     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             bit_a,
  output logic             bit_b,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eq,
  output logic             out_gt,
  output logic             out_lt,
  output logic [CW-1:0]    out_bits,
  output logic             err
);

  localparam logic [CW-1:0] C_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [CW-1:0]      issue_q, issue_d, res_q, res_d, bits_q, bits_d;
  logic [CMP_LAT-1:0] tag_q, tag_d;
  logic [2:0]         rel_q, rel_d;
  logic               err_q, err_d;
  logic               live_q;
  logic               push;
  logic               tag_out;
  logic [2:0]         cmp_v;
  logic               cmp_onehot;

  assign tag_out    = tag_q[CMP_LAT-1];
  assign cmp_v      = {cmp_eq, cmp_gt, cmp_lt};
  assign cmp_onehot = (cmp_v == 3'b100) || (cmp_v == 3'b010) || (cmp_v == 3'b001);

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    issue_d = issue_q;
    res_d   = res_q;
    bits_d  = bits_q;
    tag_d   = tag_q;
    rel_d   = rel_q;
    err_d   = err_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sh_a_d  = in_a;
          sh_b_d  = in_b;
          issue_d = '0;
          res_d   = '0;
          tag_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Zero fill means the MSBs read 0 once every bit has been issued.
        push = (issue_q != C_FULL);
        if (push) begin
          sh_a_d  = sh_a_q << 1;
          sh_b_d  = sh_b_q << 1;
          issue_d = issue_q + CW'(1);
        end
        tag_d    = tag_q << 1;
        tag_d[0] = push;
        if (tag_out) begin
          res_d = res_q + CW'(1);
          if (!cmp_onehot) begin
            err_d   = 1'b1;
            rel_d   = 3'b000;
            state_d = DONE;
          end else if (cmp_gt) begin
            rel_d   = 3'b010;
            state_d = DONE;
          end else if (cmp_lt) begin
            rel_d   = 3'b001;
            state_d = DONE;
          end else if (res_q == C_LAST) begin
            rel_d   = 3'b100;
            state_d = DONE;
          end
          if (state_d == DONE) begin
            bits_d = res_q + CW'(1);
            tag_d  = '0;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      issue_q <= '0;
      res_q   <= '0;
      bits_q  <= '0;
      tag_q   <= '0;
      rel_q   <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      issue_q <= issue_d;
      res_q   <= res_d;
      bits_q  <= bits_d;
      tag_q   <= tag_d;
      rel_q   <= rel_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  // live_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = live_q && (state_q == IDLE);
  assign bit_a     = (state_q == SHIFT) && sh_a_q[WIDTH-1];
  assign bit_b     = (state_q == SHIFT) && sh_b_q[WIDTH-1];
  assign out_valid = (state_q == DONE);
  assign out_eq    = rel_q[2];
  assign out_gt    = rel_q[1];
  assign out_lt    = rel_q[0];
  assign out_bits  = bits_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_comparator_word_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// Randomised bench for comparator_word_sequencer; includes a registered
// 1-bit comparator model and a word-level reference for timing and result.
module tb_comparator_word_sequencer;

  localparam int W   = 8;
  localparam int LAT = 1;
  localparam int CW  = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          bit_a, bit_b;
  logic          cmp_eq, cmp_gt, cmp_lt;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_eq, out_gt, out_lt;
  logic [CW-1:0] out_bits;
  logic          err;
  logic          fault = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_err  = 1'b0;

  always #5 clk = ~clk;

  comparator_word_sequencer #(.WIDTH(W), .CMP_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .bit_a(bit_a), .bit_b(bit_b),
    .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_eq(out_eq), .out_gt(out_gt), .out_lt(out_lt),
    .out_bits(out_bits), .err(err)
  );

  // Registered 1-bit comparator, LAT stages deep; fault makes eq and gt both high.
  logic [2:0] cpipe [LAT];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) cpipe[i] <= 3'b000;
    end else begin
      cpipe[0] <= {bit_a == bit_b, bit_a & ~bit_b, ~bit_a & bit_b};
      for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
    end
  end
  assign cmp_eq = cpipe[LAT-1][2] | fault;
  assign cmp_gt = cpipe[LAT-1][1] | fault;
  assign cmp_lt = cpipe[LAT-1][0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit flt, input int hold);
    int          d, c, exp_c, guard, bad;
    logic [2:0]  exp_rel, rel0;
    logic [CW-1:0] bits0;
    logic [31:0] ba, bb, ea, eb;
    // Decision index: first differing bit counted from the MSB, else all bits.
    d = W;
    for (int i = W - 1; i >= 0; i--) begin
      if (a[i] != b[i]) begin
        d = W - i;
        break;
      end
    end
    if (flt) d = 1;
    if (flt)         exp_rel = 3'b000;
    else if (a == b) exp_rel = 3'b100;
    else if (a > b)  exp_rel = 3'b010;
    else             exp_rel = 3'b001;
    exp_c = 1 + d + LAT;
    ea = '0;
    eb = '0;
    for (int k = 0; k < d + LAT; k++) begin
      if (k < W) begin
        ea[k] = a[W-1-k];
        eb[k] = b[W-1-k];
      end
    end

    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_wait", 32'(in_ready), 32'd1);
      return;
    end
    fault     = flt;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    out_ready = (hold == 0);
    @(posedge clk);
    c  = 0;
    ba = '0;
    bb = '0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      c++;
      if (c <= 32) begin
        ba[c-1] = bit_a;
        bb[c-1] = bit_b;
      end
    end while (!out_valid && c < 40);
    fault = 1'b0;

    check("valid_cycle", 32'(c), 32'(exp_c));
    check("relation", 32'({out_eq, out_gt, out_lt}), 32'(exp_rel));
    check("out_bits", 32'(out_bits), 32'(d));
    if (!flt) begin
      check("bit_a_seq", ba, ea);
      check("bit_b_seq", bb, eb);
    end
    exp_err = exp_err | flt;
    check("err", 32'(err), 32'(exp_err));

    if (hold > 0) begin
      rel0  = {out_eq, out_gt, out_lt};
      bits0 = out_bits;
      bad   = 0;
      for (int i = 0; i < hold; i++) begin
        if (!out_valid || in_ready || ({out_eq, out_gt, out_lt} != rel0) || (out_bits != bits0))
          bad++;
        @(negedge clk);
      end
      check("backpressure_hold", 32'(bad), 32'd0);
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("post_accept", 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int mode;
    #2;
    check("reset_vals",
          32'({in_ready, bit_a, bit_b, out_valid, out_eq, out_gt, out_lt, out_bits, err}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready), 32'd1);

    do_txn(8'h80, 8'h00, 1'b0, 0);
    do_txn(8'hA5, 8'hA5, 1'b0, 0);
    do_txn(8'h3C, 8'h3D, 1'b0, 0);
    do_txn(8'hFF, 8'h7F, 1'b0, 0);
    do_txn(8'h10, 8'h20, 1'b0, 5);
    do_txn(8'h33, 8'h33, 1'b1, 0);
    do_txn(8'h12, 8'h34, 1'b0, 0);

    // Reset in the middle of a long (all-equal) transaction.
    in_valid = 1'b1;
    in_a     = 8'h5A;
    in_b     = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("bit_a_before_reset", 32'(bit_a), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_shift_reset", 32'({err, out_valid, bit_a, bit_b, in_ready}), 32'd0);
    exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_mid_reset", 32'(in_ready), 32'd1);

    for (int t = 0; t < 24; t++) begin
      ra   = W'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 0)      rb = W'($urandom);
      else if (mode == 1) rb = ra;
      else                rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
      do_txn(ra, rb, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
